// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control sequencer for the MIPS core.  Owns the instruction
// state register and turns opcode/function decode into datapath enables.
// Adds RAM wait-state stalls, sub-word byte enables derived from the low
// address bits, a fixed-length mul/div busy phase and halt when PC == 0.
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous active-high reset
//   opcode_i, function_i  instruction fields (valid outside FETCH)
//   addr_low_i            effective data address bits [1:0]
//   waitrequest_i         RAM busy, holds the current access
//   pc_zero_i             PC equals zero (only looked at in FETCH)
//   state_o               FETCH=0 EXEC1=1 EXEC2=2 MULDIV=3 HALTED=4
//   active_o              low only in HALTED
//   pc/ir/ram/regfile enables, ram_byte_en_o, ram_addr_sel_o (0=PC, 1=ALU),
//   src_b_sel_o (0=rt, 1=imm), regfile_addr_3_sel_o (RT=0 RD=1 RA=2),
//   muldiv_start_o        one-cycle start pulse to the mul/div unit
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = $clog2(MULDIV_CYCLES) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic [5:0] function_i,
    input  logic [1:0] addr_low_i,
    input  logic       waitrequest_i,
    input  logic       pc_zero_i,
    output logic [2:0] state_o,
    output logic       active_o,
    output logic       pc_write_en_o,
    output logic       ir_write_en_o,
    output logic       ram_write_en_o,
    output logic       ram_read_en_o,
    output logic [3:0] ram_byte_en_o,
    output logic       ram_addr_sel_o,
    output logic       src_b_sel_o,
    output logic       regfile_write_en_o,
    output logic [1:0] regfile_addr_3_sel_o,
    output logic       muldiv_start_o
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_EXEC1  = 3'd1;
    localparam logic [2:0] S_EXEC2  = 3'd2;
    localparam logic [2:0] S_MULDIV = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [1:0] SEL_RT = 2'd0;
    localparam logic [1:0] SEL_RD = 2'd1;
    localparam logic [1:0] SEL_RA = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ir_loaded;

    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ir_loaded_next;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_is_muldiv;
    logic             w_is_imm;
    logic             w_rf_write;
    logic [1:0]       w_rf_sel;
    logic [1:0]       w_size;
    logic [3:0]       w_data_be;
    logic             w_e2_exit;

    // ---------------------------------------------------------------------
    // Instruction class decode.  Anything not listed falls through as a NOP
    // that only advances the PC.
    // ---------------------------------------------------------------------
    always_comb begin
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_muldiv = 1'b0;
        w_is_imm    = 1'b0;
        w_rf_write  = 1'b0;
        w_rf_sel    = SEL_RT;
        w_size      = SZ_WORD;
        case (opcode_i)
            6'h00: begin
                case (function_i)
                    6'h18, 6'h19, 6'h1A, 6'h1B: w_is_muldiv = 1'b1;
                    // shifts, JALR, MFHI/MFLO, ALU register ops
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09,
                    6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        w_rf_write = 1'b1;
                        w_rf_sel   = SEL_RD;
                    end
                    default: ;
                endcase
            end
            6'h03: begin
                w_rf_write = 1'b1;
                w_rf_sel   = SEL_RA;
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_is_imm   = 1'b1;
                w_rf_write = 1'b1;
            end
            6'h20, 6'h24: begin
                w_is_load  = 1'b1;
                w_rf_write = 1'b1;
                w_size     = SZ_BYTE;
            end
            6'h21, 6'h25: begin
                w_is_load  = 1'b1;
                w_rf_write = 1'b1;
                w_size     = SZ_HALF;
            end
            6'h23: begin
                w_is_load  = 1'b1;
                w_rf_write = 1'b1;
            end
            6'h28: begin
                w_is_store = 1'b1;
                w_size     = SZ_BYTE;
            end
            6'h29: begin
                w_is_store = 1'b1;
                w_size     = SZ_HALF;
            end
            6'h2B: w_is_store = 1'b1;
            default: ;
        endcase
    end

    // Little-endian lane mask; misaligned addresses simply yield the mask.
    always_comb begin
        case (w_size)
            SZ_BYTE: w_data_be = 4'b0001 << addr_low_i;
            SZ_HALF: w_data_be = addr_low_i[1] ? 4'b1100 : 4'b0011;
            default: w_data_be = 4'b1111;
        endcase
    end

    // A store held by waitrequest must not retire yet.
    assign w_e2_exit = !(w_is_store && waitrequest_i);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_FETCH: begin
                if (pc_zero_i) begin
                    w_state_next = S_HALTED;
                end else if (!waitrequest_i) begin
                    w_state_next = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (w_is_load) begin
                    if (!waitrequest_i) begin
                        w_state_next = S_EXEC2;
                    end
                end else if (w_is_muldiv) begin
                    w_state_next = S_MULDIV;
                    w_cnt_next   = CNT_LOAD;
                end else begin
                    w_state_next = S_EXEC2;
                end
            end
            S_MULDIV: begin
                // counter value 0 marks the last busy cycle
                if (r_cnt == '0) begin
                    w_state_next = S_EXEC2;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_EXEC2: begin
                if (w_e2_exit) begin
                    w_state_next = S_FETCH;
                end
            end
            S_HALTED: ;
            default: w_state_next = S_FETCH;
        endcase
    end

    // Set only while EXEC1 is being held, so it clears as EXEC1 is left.
    assign w_ir_loaded_next = (r_state == S_EXEC1) && (w_state_next == S_EXEC1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_cnt       <= '0;
            r_ir_loaded <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_ir_loaded <= w_ir_loaded_next;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: combinational from state, flags and inputs.  Reset gates
    // every enable so nothing is written while reset is high.
    // ---------------------------------------------------------------------
    always_comb begin
        state_o              = r_state;
        active_o             = (r_state != S_HALTED);
        pc_write_en_o        = 1'b0;
        ir_write_en_o        = 1'b0;
        ram_write_en_o       = 1'b0;
        ram_read_en_o        = 1'b0;
        ram_byte_en_o        = 4'b0000;
        ram_addr_sel_o       = 1'b0;
        src_b_sel_o          = 1'b0;
        regfile_write_en_o   = 1'b0;
        regfile_addr_3_sel_o = SEL_RT;
        muldiv_start_o       = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (!pc_zero_i) begin
                    ram_read_en_o = 1'b1;
                    ram_byte_en_o = 4'b1111;
                end
            end
            S_EXEC1: begin
                ir_write_en_o = !r_ir_loaded;
                if (w_is_load) begin
                    ram_read_en_o  = 1'b1;
                    ram_addr_sel_o = 1'b1;
                    src_b_sel_o    = 1'b1;
                    ram_byte_en_o  = w_data_be;
                end
                if (w_is_muldiv) begin
                    muldiv_start_o = !r_ir_loaded;
                end
            end
            S_EXEC2: begin
                regfile_addr_3_sel_o = w_rf_sel;
                if (w_is_store) begin
                    ram_write_en_o = 1'b1;
                    ram_addr_sel_o = 1'b1;
                    src_b_sel_o    = 1'b1;
                    ram_byte_en_o  = w_data_be;
                end
                if (w_is_imm) begin
                    src_b_sel_o = 1'b1;
                end
                if (w_e2_exit) begin
                    pc_write_en_o      = 1'b1;
                    regfile_write_en_o = w_rf_write;
                end
            end
            default: ;
        endcase
        if (reset) begin
            active_o             = 1'b1;
            pc_write_en_o        = 1'b0;
            ir_write_en_o        = 1'b0;
            ram_write_en_o       = 1'b0;
            ram_read_en_o        = 1'b0;
            ram_byte_en_o        = 4'b0000;
            ram_addr_sel_o       = 1'b0;
            src_b_sel_o          = 1'b0;
            regfile_write_en_o   = 1'b0;
            regfile_addr_3_sel_o = SEL_RT;
            muldiv_start_o       = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Testbench for cpu_sequencer with MULDIV_CYCLES=4.  Directed vector table,
// hand-written reset/halt sequences and randomized instructions checked
// against a cycle trace built from instruction class and wait counts.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam int MD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode_i, function_i;
    logic [1:0] addr_low_i;
    logic       waitrequest_i, pc_zero_i;
    logic [2:0] state_o;
    logic       active_o, pc_write_en_o, ir_write_en_o, ram_write_en_o, ram_read_en_o;
    logic [3:0] ram_byte_en_o;
    logic       ram_addr_sel_o, src_b_sel_o, regfile_write_en_o;
    logic [1:0] regfile_addr_3_sel_o;
    logic       muldiv_start_o;

    cpu_sequencer #(.MULDIV_CYCLES(MD)) dut (
        .clk                  (clk),
        .reset                (reset),
        .opcode_i             (opcode_i),
        .function_i           (function_i),
        .addr_low_i           (addr_low_i),
        .waitrequest_i        (waitrequest_i),
        .pc_zero_i            (pc_zero_i),
        .state_o              (state_o),
        .active_o             (active_o),
        .pc_write_en_o        (pc_write_en_o),
        .ir_write_en_o        (ir_write_en_o),
        .ram_write_en_o       (ram_write_en_o),
        .ram_read_en_o        (ram_read_en_o),
        .ram_byte_en_o        (ram_byte_en_o),
        .ram_addr_sel_o       (ram_addr_sel_o),
        .src_b_sel_o          (src_b_sel_o),
        .regfile_write_en_o   (regfile_write_en_o),
        .regfile_addr_3_sel_o (regfile_addr_3_sel_o),
        .muldiv_start_o       (muldiv_start_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       act, pcw, irw, ramw, ramr;
        logic [3:0] be;
        logic       asel, bsel, rfw;
        logic [1:0] rsel;
        logic       mds;
    } outv_t;

    typedef struct packed {
        logic  wr;
        logic  pz;
        outv_t e;
    } cyc_t;

    typedef struct {
        string      name;
        logic [5:0] op, fn;
        logic [1:0] al;
        int         fw, dw, ws;
        int         x_cyc;
        logic [3:0] x_be;
        int         x_rfw;
        logic [1:0] x_rsel;
        int         x_mds;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    cyc_t q[$];

    function automatic outv_t base(input logic [2:0] st);
        outv_t e;
        e     = '0;
        e.st  = st;
        e.act = (st != 3'd4);
        return e;
    endfunction

    function automatic outv_t dut_out();
        outv_t o;
        o.st   = state_o;
        o.act  = active_o;
        o.pcw  = pc_write_en_o;
        o.irw  = ir_write_en_o;
        o.ramw = ram_write_en_o;
        o.ramr = ram_read_en_o;
        o.be   = ram_byte_en_o;
        o.asel = ram_addr_sel_o;
        o.bsel = src_b_sel_o;
        o.rfw  = regfile_write_en_o;
        o.rsel = regfile_addr_3_sel_o;
        o.mds  = muldiv_start_o;
        return o;
    endfunction

    task automatic chk(input string name, input outv_t got, input outv_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h required %05h (st=%0d vs %0d)",
                     name, got, exp, got.st, exp.st);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Instruction classes: kind 0=plain, 1=load, 2=store, 3=mul/div.
    // sz 0=byte, 1=half, 2=word.
    task automatic classify(input logic [5:0] op, input logic [5:0] fn,
                            output int kind, output int sz, output logic rf,
                            output logic [1:0] rs, output logic imm);
        kind = 0; sz = 2; rf = 1'b0; rs = 2'd0; imm = 1'b0;
        case (op)
            6'h00: begin
                if (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B}) kind = 3;
                else if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09,
                                    6'h10, 6'h12, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
                    rf = 1'b1; rs = 2'd1;
                end
            end
            6'h03: begin rf = 1'b1; rs = 2'd2; end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin rf = 1'b1; imm = 1'b1; end
            6'h20, 6'h24: begin kind = 1; sz = 0; rf = 1'b1; end
            6'h21, 6'h25: begin kind = 1; sz = 1; rf = 1'b1; end
            6'h23:        begin kind = 1; sz = 2; rf = 1'b1; end
            6'h28: begin kind = 2; sz = 0; end
            6'h29: begin kind = 2; sz = 1; end
            6'h2B: begin kind = 2; sz = 2; end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] lane_mask(input int sz, input logic [1:0] al);
        if (sz == 2) return 4'b1111;
        if (sz == 1) return al[1] ? 4'b1100 : 4'b0011;
        return 4'b0001 << al;
    endfunction

    // Expected per-cycle trace: FETCH for fw wait cycles + 1, then EXEC1
    // (held dw cycles for loads, plus MD busy cycles for mul/div), then
    // EXEC2 (held dw cycles for stores).  Non-access cycles get random
    // waitrequest / pc_zero noise that must be ignored.
    task automatic build_trace(input logic [5:0] op, input logic [5:0] fn,
                               input logic [1:0] al, input int fw, input int dw);
        int kind, sz; logic rf, imm; logic [1:0] rs; cyc_t c; logic [3:0] m;
        classify(op, fn, kind, sz, rf, rs, imm);
        m = lane_mask(sz, al);
        q.delete();
        for (int i = 0; i <= fw; i++) begin
            c.e = base(3'd0); c.e.ramr = 1'b1; c.e.be = 4'b1111;
            c.wr = (i < fw); c.pz = 1'b0; q.push_back(c);
        end
        if (kind == 1) begin
            for (int i = 0; i <= dw; i++) begin
                c.e = base(3'd1); c.e.irw = (i == 0); c.e.ramr = 1'b1;
                c.e.asel = 1'b1; c.e.bsel = 1'b1; c.e.be = m;
                c.wr = (i < dw); c.pz = 1'($urandom); q.push_back(c);
            end
        end else begin
            c.e = base(3'd1); c.e.irw = 1'b1; c.e.mds = (kind == 3);
            c.wr = 1'($urandom); c.pz = 1'($urandom); q.push_back(c);
            if (kind == 3) begin
                for (int i = 0; i < MD; i++) begin
                    c.e = base(3'd3); c.wr = 1'($urandom); c.pz = 1'($urandom);
                    q.push_back(c);
                end
            end
        end
        if (kind == 2) begin
            for (int i = 0; i <= dw; i++) begin
                c.e = base(3'd2); c.e.ramw = 1'b1; c.e.asel = 1'b1; c.e.bsel = 1'b1;
                c.e.be = m; c.e.pcw = (i == dw);
                c.wr = (i < dw); c.pz = 1'($urandom); q.push_back(c);
            end
        end else begin
            c.e = base(3'd2); c.e.pcw = 1'b1; c.e.rfw = rf; c.e.rsel = rs; c.e.bsel = imm;
            c.wr = 1'($urandom); c.pz = 1'($urandom); q.push_back(c);
        end
    endtask

    // Applies up to ncyc trace entries (all if ncyc < 0).  Entered and left
    // 1 time unit after a rising edge; outputs sampled 2 units later.
    task automatic apply_trace(input logic [5:0] op, input logic [5:0] fn,
                               input logic [1:0] al, input string name, input int ncyc);
        cyc_t c; int n;
        n = 0;
        while (q.size() > 0 && (ncyc < 0 || n < ncyc)) begin
            c = q.pop_front();
            if (c.e.st == 3'd0) begin
                opcode_i = 6'($urandom); function_i = 6'($urandom);
            end else begin
                opcode_i = op; function_i = fn;
            end
            addr_low_i = al; waitrequest_i = c.wr; pc_zero_i = c.pz;
            #2;
            chk(name, dut_out(), c.e);
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Directed vector: drive waits by observed state, summarize what the
    // DUT did over one instruction and compare with the table expectations.
    task automatic run_vec(input vec_t v);
        int fl, dl, cyc, irw_n, pcw_n, mds_n, rfw_n;
        logic [3:0] be; logic [1:0] rs; logic done;
        fl = v.fw; dl = v.dw; cyc = 0; irw_n = 0; pcw_n = 0; mds_n = 0; rfw_n = 0;
        be = 4'b0000; rs = 2'd0; done = 1'b0;
        opcode_i = v.op; function_i = v.fn; addr_low_i = v.al; pc_zero_i = 1'b0;
        while (!done && cyc < 100) begin
            waitrequest_i = 1'b0;
            if (state_o == 3'd0 && fl > 0) begin
                waitrequest_i = 1'b1; fl--;
            end else if (state_o == 3'(v.ws) && dl > 0) begin
                waitrequest_i = 1'b1; dl--;
            end
            #2;
            cyc++;
            irw_n += int'(ir_write_en_o);
            pcw_n += int'(pc_write_en_o);
            mds_n += int'(muldiv_start_o);
            if ((ram_read_en_o || ram_write_en_o) && ram_addr_sel_o) be = ram_byte_en_o;
            if (regfile_write_en_o) begin rfw_n++; rs = regfile_addr_3_sel_o; end
            if (state_o == 3'd2 && pc_write_en_o) done = 1'b1;
            @(posedge clk); #1;
        end
        chk_int({v.name, " finished"}, int'(done), 1);
        chk_int({v.name, " cycles"}, cyc, v.x_cyc);
        chk_int({v.name, " byte_en"}, int'(be), int'(v.x_be));
        chk_int({v.name, " ir_write pulses"}, irw_n, 1);
        chk_int({v.name, " pc_write pulses"}, pcw_n, 1);
        chk_int({v.name, " regfile writes"}, rfw_n, v.x_rfw);
        chk_int({v.name, " regfile sel"}, int'(rs), int'(v.x_rsel));
        chk_int({v.name, " muldiv_start pulses"}, mds_n, v.x_mds);
        $display("txn %s op=%02h fn=%02h al=%0d cycles=%0d be=%b", v.name, v.op, v.fn, v.al, cyc, be);
    endtask

    vec_t vecs[16];
    logic [11:0] ilist[28];

    initial begin
        logic [5:0] op, fn; logic [1:0] al; int fw, dw; outv_t e;

        vecs[0]  = '{"ADDU",    6'h00, 6'h21, 2'd0, 0, 0, 1, 3, 4'h0, 1, 2'd1, 0};
        vecs[1]  = '{"LH_al2",  6'h21, 6'h00, 2'd2, 0, 2, 1, 5, 4'hC, 1, 2'd0, 0};
        vecs[2]  = '{"SB_al0",  6'h28, 6'h00, 2'd0, 0, 1, 2, 4, 4'h1, 0, 2'd0, 0};
        vecs[3]  = '{"SB_al1",  6'h28, 6'h00, 2'd1, 0, 1, 2, 4, 4'h2, 0, 2'd0, 0};
        vecs[4]  = '{"SB_al2",  6'h28, 6'h00, 2'd2, 0, 1, 2, 4, 4'h4, 0, 2'd0, 0};
        vecs[5]  = '{"SB_al3",  6'h28, 6'h00, 2'd3, 0, 1, 2, 4, 4'h8, 0, 2'd0, 0};
        vecs[6]  = '{"MULT",    6'h00, 6'h18, 2'd0, 0, 0, 1, 7, 4'h0, 0, 2'd0, 1};
        vecs[7]  = '{"JAL",     6'h03, 6'h00, 2'd0, 0, 0, 1, 3, 4'h0, 1, 2'd2, 0};
        vecs[8]  = '{"LW_fw2",  6'h23, 6'h00, 2'd3, 2, 0, 1, 5, 4'hF, 1, 2'd0, 0};
        vecs[9]  = '{"SH_al2",  6'h29, 6'h00, 2'd2, 0, 0, 2, 3, 4'hC, 0, 2'd0, 0};
        vecs[10] = '{"ORI",     6'h0D, 6'h00, 2'd0, 0, 0, 1, 3, 4'h0, 1, 2'd0, 0};
        vecs[11] = '{"UNKNOWN", 6'h3F, 6'h00, 2'd0, 0, 0, 1, 3, 4'h0, 0, 2'd0, 0};
        vecs[12] = '{"DIVU",    6'h00, 6'h1B, 2'd0, 0, 0, 1, 7, 4'h0, 0, 2'd0, 1};
        vecs[13] = '{"LBU_al1", 6'h24, 6'h00, 2'd1, 1, 1, 1, 5, 4'h2, 1, 2'd0, 0};
        vecs[14] = '{"JR",      6'h00, 6'h08, 2'd0, 0, 0, 1, 3, 4'h0, 0, 2'd0, 0};
        vecs[15] = '{"MTHI",    6'h00, 6'h11, 2'd0, 0, 0, 1, 3, 4'h0, 0, 2'd0, 0};

        ilist = '{{6'h00, 6'h21}, {6'h00, 6'h00}, {6'h00, 6'h2A}, {6'h00, 6'h09},
                  {6'h00, 6'h10}, {6'h00, 6'h12}, {6'h00, 6'h08}, {6'h00, 6'h11},
                  {6'h00, 6'h3F}, {6'h00, 6'h18}, {6'h00, 6'h19}, {6'h00, 6'h1A},
                  {6'h00, 6'h1B}, {6'h03, 6'h00}, {6'h09, 6'h00}, {6'h0F, 6'h00},
                  {6'h0A, 6'h00}, {6'h20, 6'h00}, {6'h21, 6'h00}, {6'h23, 6'h00},
                  {6'h24, 6'h00}, {6'h25, 6'h00}, {6'h28, 6'h00}, {6'h29, 6'h00},
                  {6'h2B, 6'h00}, {6'h3F, 6'h00}, {6'h02, 6'h00}, {6'h0C, 6'h00}};

        // Reset: state FETCH, active, no enables even with inputs that
        // would otherwise request a fetch.
        reset = 1'b1; opcode_i = 6'h23; function_i = 6'h00; addr_low_i = 2'd0;
        waitrequest_i = 1'b0; pc_zero_i = 1'b0;
        #1;
        chk("reset_async", dut_out(), base(3'd0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            waitrequest_i = 1'($urandom); pc_zero_i = 1'($urandom);
            #2;
            chk("reset_held", dut_out(), base(3'd0));
        end
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // JAL via trace, then FETCH with PC zero: halt and stay halted.
        build_trace(6'h03, 6'h00, 2'd0, 0, 0);
        apply_trace(6'h03, 6'h00, 2'd0, "jal_trace", -1);
        opcode_i = 6'($urandom); waitrequest_i = 1'b0; pc_zero_i = 1'b1;
        #2;
        chk("halt_fetch", dut_out(), base(3'd0));
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            opcode_i = 6'($urandom); function_i = 6'($urandom);
            waitrequest_i = 1'($urandom); pc_zero_i = 1'($urandom);
            #2;
            chk("halted", dut_out(), base(3'd4));
            @(posedge clk); #1;
        end
        $display("txn HALT after JAL: 10 halted cycles");
        reset = 1'b1; pc_zero_i = 1'b0;
        #1;
        chk("reset_from_halt", dut_out(), base(3'd0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset in the middle of MULDIV.
        build_trace(6'h00, 6'h18, 2'd0, 0, 0);
        apply_trace(6'h00, 6'h18, 2'd0, "mult_pre_reset", 4);
        waitrequest_i = 1'b0; pc_zero_i = 1'b0;
        #1;
        chk("mult_in_muldiv", dut_out(), base(3'd3));
        reset = 1'b1;
        #1;
        chk("reset_mid_muldiv", dut_out(), base(3'd0));
        @(posedge clk); #1;
        chk("reset_mid_muldiv_held", dut_out(), base(3'd0));
        reset = 1'b0;
        $display("txn RESET during MULDIV");

        // Reset during a stalled store: write enable drops immediately.
        build_trace(6'h2B, 6'h00, 2'd0, 0, 3);
        apply_trace(6'h2B, 6'h00, 2'd0, "sw_pre_reset", 3);
        opcode_i = 6'h2B; waitrequest_i = 1'b1; pc_zero_i = 1'b0;
        #1;
        e = base(3'd2); e.ramw = 1'b1; e.asel = 1'b1; e.bsel = 1'b1; e.be = 4'hF;
        chk("sw_stalled", dut_out(), e);
        reset = 1'b1;
        #1;
        chk("reset_mid_store", dut_out(), base(3'd0));
        @(posedge clk); #1;
        reset = 1'b0;
        $display("txn RESET during SW stall");

        // Randomized instructions against the trace model.
        for (int k = 0; k < 80; k++) begin
            int idx;
            idx = $urandom_range(0, 27);
            op = ilist[idx][11:6];
            fn = (op == 6'h00) ? ilist[idx][5:0] : 6'($urandom);
            al = 2'($urandom);
            fw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            build_trace(op, fn, al, fw, dw);
            $display("txn rnd %0d op=%02h fn=%02h al=%0d fw=%0d dw=%0d cycles=%0d",
                     k, op, fn, al, fw, dw, q.size());
            apply_trace(op, fn, al, "random", -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
